// File: rtl/rotate_right_sequencer_if.sv
// Bus bundle for the multi-cycle right-rotate unit: request/operand
// signals from the requester and result/status back from the unit.
interface rotate_right_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
);
   logic             start;
   logic [WIDTH-1:0] b;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] shr;
   logic             busy;
   logic             done;
   logic             zero;
   logic             sign;

   modport master (
      output start, b, count,
      input  shr, busy, done, zero, sign
   );

   modport slave (
      input  start, b, count,
      output shr, busy, done, zero, sign
   );
endinterface

// File: rtl/rotate_right_sequencer.sv
// Multi-cycle circular right-rotate: one bit position per clock, result
// register plus zero/sign flags loaded together when the rotation completes,
// followed by a one-cycle done pulse. A start seen in DONE is accepted
// immediately so operations can run back to back.
module rotate_right_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   rotate_right_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sreg;
   logic [CNT_W-1:0] r_rem;
   logic [WIDTH-1:0] r_shr;
   logic             r_zero;
   logic             r_sign;

   logic             w_busy;
   logic             w_done;
   logic             w_accept;
   logic             w_last;
   logic             w_load;
   logic [WIDTH-1:0] w_rot;
   logic [WIDTH-1:0] w_load_val;

   // Single-position circular right rotate; the LSB wraps into the MSB.
   function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] x);
      return {x[0], x[WIDTH-1:1]};
   endfunction

   // A request is taken whenever no rotation is in flight (IDLE or DONE).
   assign w_accept   = bus.start && (r_state != S_SHIFT);
   assign w_rot      = rotr1(r_sreg);
   assign w_last     = (r_state == S_SHIFT) && (r_rem == CNT_W'(1));
   // Result loads either on a zero-count accept (operand passes straight
   // through) or on the final rotate step (rotated value written directly).
   assign w_load     = (w_accept && (bus.count == '0)) || w_last;
   assign w_load_val = w_last ? w_rot : bus.b;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and status decode.
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nxt = (bus.count == '0) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            w_busy = 1'b1;
            if (r_rem == CNT_W'(1)) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            if (bus.start) w_state_nxt = (bus.count == '0) ? S_DONE : S_SHIFT;
            else           w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shift register and remaining count: capture on accept, step while shifting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sreg <= '0;
         r_rem  <= '0;
      end else if (w_accept) begin
         r_sreg <= bus.b;
         r_rem  <= bus.count;
      end else if (r_state == S_SHIFT) begin
         r_sreg <= w_rot;
         r_rem  <= r_rem - CNT_W'(1);
      end
   end

   // Result and flags change only on entry to DONE, always from the same value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shr  <= '0;
         r_zero <= 1'b1;
         r_sign <= 1'b0;
      end else if (w_load) begin
         r_shr  <= w_load_val;
         r_zero <= (w_load_val == '0);
         r_sign <= w_load_val[WIDTH-1];
      end
   end

   assign bus.shr  = r_shr;
   assign bus.zero = r_zero;
   assign bus.sign = r_sign;
   assign bus.busy = w_busy;
   assign bus.done = w_done;

endmodule
